// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and default sizing for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational rotating-priority encoder (module rr_pick)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan from rr_ptr upward, wrapping, and keep the first hit.
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                idx   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter onto a shared FIFO; FIFO_ARB_STATS_EN adds stall_cnt
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   din,
    output logic [NUM_REQ-1:0]          gnt,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           fifo_din,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]                 stall_cnt
`endif
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t     r_state;
    arb_state_t     w_state_nxt;
    logic [OW-1:0]  r_owner;
    logic [OW-1:0]  w_owner_nxt;
    logic [OW-1:0]  r_rr_ptr;
    logic [OW-1:0]  w_rr_nxt;
    logic [OW-1:0]  w_owner_inc;
    logic [OW-1:0]  w_pick_idx;
    logic           w_pick_found;
    logic [BW-1:0]  r_beat_cnt;
    logic [BW-1:0]  w_beat_nxt;
    logic           w_req_own;
    logic           w_wr_en;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .idx    (w_pick_idx),
        .found  (w_pick_found)
    );

    assign w_req_own   = req[r_owner];
    assign w_owner_inc = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        w_wr_en     = 1'b0;
        fifo_din    = '0;
        gnt         = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_owner_nxt = w_pick_idx;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Reset suppresses the write in the very cycle it arrives.
                w_wr_en      = w_req_own && !fifo_full && !reset;
                fifo_din     = din[r_owner*DATA_W +: DATA_W];
                gnt[r_owner] = w_wr_en;
                if (!w_req_own || (w_wr_en && r_beat_cnt == BW'(MAX_BURST - 1))) begin
                    w_state_nxt = IDLE;
                    w_rr_nxt    = w_owner_inc;
                    w_beat_nxt  = '0;
                end else if (w_wr_en) begin
                    w_beat_nxt  = r_beat_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    assign fifo_wr_en = w_wr_en;
    assign busy       = (r_state == GRANT);
    assign owner      = r_owner;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_state == GRANT && w_req_own && fifo_full && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of writer requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the data width per requester.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant (1..16).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester write request, held while data is valid.
REQ-007 The block SHALL have port din, input, NUM_REQ*DATA_W bits: requester i's data is in slice [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port gnt, output, NUM_REQ bits: one-hot beat-accepted strobe for the owning requester.
REQ-009 The block SHALL have port fifo_full, input, 1 bit: full flag from the shared FIFO.
REQ-010 The block SHALL have port fifo_wr_en, output, 1 bit: write enable to the shared FIFO.
REQ-011 The block SHALL have port fifo_din, output, DATA_W bits: write data to the shared FIFO.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in the GRANT state.
REQ-013 The block SHALL have port owner, output, $clog2(NUM_REQ) bits: index of the current owner, valid only while busy is high.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-015 In IDLE with any req bit set, the block SHALL select the first set bit at or after rr_ptr (wrapping modulo NUM_REQ), register it as owner, and enter GRANT on the next edge (one cycle of arbitration latency).
REQ-016 In IDLE with req equal to 0, the block SHALL remain in IDLE.
REQ-017 In GRANT, fifo_wr_en SHALL be combinationally req[owner] && !fifo_full.
REQ-018 In GRANT, fifo_din SHALL be din[owner]; in IDLE, fifo_din SHALL be 0.
REQ-019 gnt[owner] SHALL equal fifo_wr_en; all other gnt bits SHALL be 0.
REQ-020 fifo_wr_en SHALL never be high while fifo_full is high, and SHALL never be high in IDLE.
REQ-021 The beat counter SHALL increment only on an accepted beat (fifo_wr_en high); a stall cycle (fifo_full high) SHALL leave the counter and owner unchanged.
REQ-022 GRANT SHALL exit to IDLE when req[owner] is low, or when a beat is accepted with beat count equal to MAX_BURST-1.
REQ-023 On GRANT exit, rr_ptr SHALL become (owner+1) modulo NUM_REQ and the beat counter SHALL clear.
REQ-024 Requests from non-owners during GRANT SHALL be ignored until the next IDLE arbitration; no beat is ever dropped or duplicated.
REQ-025 Every accepted beat SHALL be followed by at least one IDLE cycle before a new owner is granted.

Reset
REQ-026 While reset is high at a clock edge, the block SHALL go to IDLE with rr_ptr=0, beat counter=0 and owner=0.
REQ-027 After reset, busy, fifo_wr_en and gnt SHALL be 0 and fifo_din SHALL be 0.
REQ-028 A reset asserted mid-burst SHALL abandon the burst without issuing a write in that cycle.
REQ-029 The block SHALL have reset priority over all other events.

Configuration
REQ-030 With macro FIFO_ARB_STATS_EN defined, the block SHALL add output stall_cnt (16 bits), counting cycles in GRANT with req[owner] && fifo_full.
REQ-031 stall_cnt SHALL saturate at 16'hFFFF and SHALL clear on reset.
REQ-032 Without FIFO_ARB_STATS_EN, the stall_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, GRANT) and the default parameter constants.
REQ-034 Sub-module rr_pick SHALL implement the rotating-priority encoder (inputs req and rr_ptr; outputs idx and found) and SHALL be purely combinational.

Verification
REQ-035 Single requester: req=4'b0001, fifo_full=0, din[0]=8'hA0..A5 over 6 beats -> grant begins cycle 2, writes A0..A3, IDLE cycle, then A4, A5.
REQ-036 All four requesting continuously, MAX_BURST=4 -> owner sequence 0,1,2,3,0, with 4 beats each.
REQ-037 fifo_full held high for 3 cycles mid-burst -> fifo_wr_en=0 for those 3 cycles, beat count holds, and the burst totals exactly 4 writes.
REQ-038 Owner drops req after 2 beats while req[2] is high -> exit to IDLE, rr_ptr=owner+1, requester 2 is granted next.
REQ-039 Reset asserted during beat 2 of a burst -> no write that cycle, then busy=0, owner=0, rr_ptr=0.
REQ-040 FIFO_ARB_STATS_EN defined with 5 stall cycles -> stall_cnt=5; forced long stall -> stall_cnt holds at 16'hFFFF.
